// File: rtl/tennis_point_input_if.sv
// Point-input bundle: raw buttons and enable in, point/conflict/drop pulses and busy out.
// Drivers take the master side, the point-input block takes the slave side.
interface tennis_point_input_if;
  logic p1_btn_raw;
  logic p2_btn_raw;
  logic enable;
  logic p1_point;
  logic p2_point;
  logic conflict;
  logic dropped;
  logic busy;

  modport master (
    output p1_btn_raw, p2_btn_raw, enable,
    input  p1_point, p2_point, conflict, dropped, busy
  );

  modport slave (
    input  p1_btn_raw, p2_btn_raw, enable,
    output p1_point, p2_point, conflict, dropped, busy
  );
endinterface

// File: rtl/tennis_point_input.sv
// Referee buttons -> sync/debounce/rise -> arbiter; point pulse DEBOUNCE_CYCLES+2 cycles after press.
// No backpressure: presses arriving while locked out are reported on dropped and discarded.
module tennis_point_input #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tennis_point_input_if.slave  pt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LD = LW'(LOCKOUT_CYCLES);
  localparam logic [LW-1:0] LOCK_ONE = LW'(1);

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  logic [1:0] w_raw;
  logic [1:0] w_rise;

  assign w_raw = {pt.p2_btn_raw, pt.p1_btn_raw};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic          r_sync1;
    logic          r_sync;
    logic          r_deb;
    logic          r_deb_q;
    logic [DW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1 <= 1'b0;
        r_sync  <= 1'b0;
        r_deb   <= 1'b0;
        r_deb_q <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= w_raw[g];
        r_sync  <= r_sync1;
        r_deb_q <= r_deb;
        // Any agreement with the debounced level restarts the qualification run.
        if (r_sync == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == DEB_MAX) begin
          r_deb <= r_sync;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + DW'(1);
        end
      end
    end

    assign w_rise[g] = r_deb & ~r_deb_q;
  end

  state_t        r_state;
  state_t        w_nxt_state;
  logic [LW-1:0] r_lock_cnt;
  logic [LW-1:0] w_nxt_lock_cnt;
  logic          r_p1_point, r_p2_point, r_conflict, r_dropped;
  logic          w_nxt_p1_point, w_nxt_p2_point, w_nxt_conflict, w_nxt_dropped;
  logic          w_req;

  assign w_req = pt.enable & (|w_rise);

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_lock_cnt = r_lock_cnt;
    w_nxt_p1_point = 1'b0;
    w_nxt_p2_point = 1'b0;
    w_nxt_conflict = 1'b0;
    w_nxt_dropped  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_nxt_state    = S_LOCK;
          w_nxt_lock_cnt = LOCK_LD;
          if (&w_rise) begin
            w_nxt_conflict = 1'b1;
          end else if (w_rise[0]) begin
            w_nxt_p1_point = 1'b1;
          end else begin
            w_nxt_p2_point = 1'b1;
          end
        end
      end
      S_LOCK: begin
        // Rejected presses never extend the lockout window.
        w_nxt_dropped = w_req;
        if (r_lock_cnt <= LOCK_ONE) begin
          w_nxt_state    = S_IDLE;
          w_nxt_lock_cnt = '0;
        end else begin
          w_nxt_lock_cnt = r_lock_cnt - LOCK_ONE;
        end
      end
      default: begin
        w_nxt_state    = S_IDLE;
        w_nxt_lock_cnt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_lock_cnt <= '0;
      r_p1_point <= 1'b0;
      r_p2_point <= 1'b0;
      r_conflict <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_lock_cnt <= w_nxt_lock_cnt;
      r_p1_point <= w_nxt_p1_point;
      r_p2_point <= w_nxt_p2_point;
      r_conflict <= w_nxt_conflict;
      r_dropped  <= w_nxt_dropped;
    end
  end

  assign pt.p1_point = r_p1_point;
  assign pt.p2_point = r_p2_point;
  assign pt.conflict = r_conflict;
  assign pt.dropped  = r_dropped;
  assign pt.busy     = (r_state == S_LOCK);

endmodule

// File: tb/tb_tennis_point_input.sv
// Bench for tennis_point_input: directed scenarios plus random button traffic against a window-based model.
module tb_tennis_point_input;
  localparam int D = 4;
  localparam int L = 4;

  logic clk;
  logic rst_n;
  tennis_point_input_if pt ();

  tennis_point_input #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pt    (pt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: raw sample history per button, debounced level, pending rise, lockout remaining.
  logic [D+1:0] hist1, hist2;
  logic mdeb1, mdeb2, mrise1, mrise2;
  int   mrem;
  logic e_p1, e_p2, e_cf, e_dr, e_busy;

  int cyc, n_p1, n_p2, n_cf, n_dr, n_busy, first_p1, first_p2, first_cf;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist1 = '0; hist2 = '0;
    mdeb1 = 0; mdeb2 = 0; mrise1 = 0; mrise2 = 0;
    mrem = 0;
    e_p1 = 0; e_p2 = 0; e_cf = 0; e_dr = 0; e_busy = 0;
  endtask

  task automatic model_edge(input logic a, input logic b, input logic en);
    logic locked;
    logic q1, q2;
    e_p1 = 0; e_p2 = 0; e_cf = 0; e_dr = 0;
    locked = (mrem > 0);
    if (locked) mrem--;
    if (en && (mrise1 || mrise2)) begin
      if (!locked) begin
        if (mrise1 && mrise2) e_cf = 1;
        else if (mrise1)      e_p1 = 1;
        else                  e_p2 = 1;
        mrem = L;
      end else begin
        e_dr = 1;
      end
    end
    e_busy = (mrem > 0);
    // A level is accepted once the last D synchronised samples all disagree with it.
    hist1 = {hist1[D:0], a};
    hist2 = {hist2[D:0], b};
    q1 = mdeb1 ? ~|hist1[D+1:2] : &hist1[D+1:2];
    q2 = mdeb2 ? ~|hist2[D+1:2] : &hist2[D+1:2];
    mrise1 = q1 && !mdeb1;
    mrise2 = q2 && !mdeb2;
    if (q1) mdeb1 = ~mdeb1;
    if (q2) mdeb2 = ~mdeb2;
  endtask

  task automatic check_outs();
    chk("p1_point", pt.p1_point, e_p1);
    chk("p2_point", pt.p2_point, e_p2);
    chk("conflict", pt.conflict, e_cf);
    chk("dropped",  pt.dropped,  e_dr);
    chk("busy",     pt.busy,     e_busy);
  endtask

  task automatic clr_counts();
    cyc = 0; n_p1 = 0; n_p2 = 0; n_cf = 0; n_dr = 0; n_busy = 0;
    first_p1 = -1; first_p2 = -1; first_cf = -1;
  endtask

  task automatic step(input logic a, input logic b, input logic en);
    pt.p1_btn_raw = a;
    pt.p2_btn_raw = b;
    pt.enable     = en;
    @(posedge clk);
    model_edge(a, b, en);
    #1;
    check_outs();
    if (pt.p1_point === 1'b1) begin n_p1++; if (first_p1 < 0) first_p1 = cyc; end
    if (pt.p2_point === 1'b1) begin n_p2++; if (first_p2 < 0) first_p2 = cyc; end
    if (pt.conflict === 1'b1) begin n_cf++; if (first_cf < 0) first_cf = cyc; end
    if (pt.dropped  === 1'b1) n_dr++;
    if (pt.busy     === 1'b1) n_busy++;
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs();
    repeat (n) @(posedge clk);
    #1;
    check_outs();
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1);
  endtask

  int   run1, run2, rune;
  logic lv1, lv2, lve;

  initial begin
    pt.p1_btn_raw = 0; pt.p2_btn_raw = 0; pt.enable = 1;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    do_reset(2);
    chk("reset_busy", pt.busy, 1'b0);

    // Single press
    clr_counts();
    for (int i = 0; i < 20; i++) step(1, 0, 1);
    chk_int("single_p1_count", n_p1, 1);
    chk_int("single_p1_edge", first_p1, D + 2);
    chk_int("single_busy_cycles", n_busy, L);
    chk_int("single_others", n_p2 + n_cf + n_dr, 0);
    idle(12);

    // Glitch rejection then a real press
    clr_counts();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) step(0, 1, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 1);
    end
    chk_int("glitch_no_p2", n_p2, 0);
    clr_counts();
    for (int i = 0; i < 10; i++) step(0, 1, 1);
    chk_int("glitch_p2_count", n_p2, 1);
    chk_int("glitch_p2_edge", first_p2, D + 2);
    idle(12);

    // Simultaneous press
    clr_counts();
    for (int i = 0; i < 12; i++) step(1, 1, 1);
    chk_int("simul_conflict", n_cf, 1);
    chk_int("simul_conflict_edge", first_cf, D + 2);
    chk_int("simul_points", n_p1 + n_p2, 0);
    chk_int("simul_busy", n_busy, L);
    idle(12);

    // Lockout drop
    clr_counts();
    step(1, 0, 1);
    step(1, 0, 1);
    for (int i = 0; i < 14; i++) step(1, 1, 1);
    chk_int("drop_p1", n_p1, 1);
    chk_int("drop_dropped", n_dr, 1);
    chk_int("drop_p2", n_p2, 0);
    chk_int("drop_busy", n_busy, L);
    idle(12);

    // Enable gating
    clr_counts();
    for (int i = 0; i < 12; i++) step(1, 0, 0);
    for (int i = 0; i < 8; i++)  step(1, 0, 1);
    chk_int("gate_none", n_p1 + n_p2 + n_cf + n_dr + n_busy, 0);
    for (int i = 0; i < 8; i++)  step(0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 1);
    chk_int("gate_repress_p1", n_p1, 1);
    idle(12);

    // Reset mid-debounce with button held
    clr_counts();
    for (int i = 0; i < 4; i++) step(1, 0, 1);
    pt.p1_btn_raw = 1;
    do_reset(2);
    clr_counts();
    for (int i = 0; i < 14; i++) step(1, 0, 1);
    chk_int("rst_p1_count", n_p1, 1);
    chk_int("rst_p1_edge", first_p1, D + 2);
    idle(12);

    // Random traffic
    run1 = 0; run2 = 0; rune = 0; lv1 = 0; lv2 = 0; lve = 1;
    clr_counts();
    for (int i = 0; i < 3000; i++) begin
      if (run1 == 0) begin lv1 = 1'($urandom_range(0, 1)); run1 = $urandom_range(1, 12); end
      if (run2 == 0) begin lv2 = 1'($urandom_range(0, 1)); run2 = $urandom_range(1, 12); end
      if (rune == 0) begin lve = ($urandom_range(0, 3) != 0); rune = $urandom_range(1, 40); end
      run1--; run2--; rune--;
      if ($urandom_range(0, 499) == 0) begin
        pt.p1_btn_raw = lv1; pt.p2_btn_raw = lv2;
        do_reset(2);
      end
      step(lv1, lv2, lve);
    end
    chk("rand_exclusive", (n_p1 > 0) && (n_p2 > 0), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  always @(negedge clk) begin
    if (rst_n && pt.p1_point === 1'b1 && pt.p2_point === 1'b1) begin
      total++;
      bad++;
      $error("FAIL both_points observed=11 expected=not both");
    end
  end

endmodule
